// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and counter width for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/mux_16w_2_1.sv
// rtl/mux_16w_2_1.sv - 16-bit two-input multiplexer, Sel=1 picks in1_i
module mux_16w_2_1 (
    input  logic [15:0] in0_i,
    input  logic [15:0] in1_i,
    input  logic        Sel,
    output logic [15:0] out_o
);

    assign out_o = Sel ? in1_i : in0_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for a single memory port with wait timeout
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_wr,
    input  logic        b_wr,
    input  logic [15:0] a_addr,
    input  logic [15:0] b_addr,
    input  logic [15:0] a_wdata,
    input  logic [15:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_done,
    output logic        b_done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done
);

    // WAIT is abandoned in the cycle the counter would step onto TIMEOUT,
    // so an unanswered access spends exactly TIMEOUT cycles in WAIT.
    localparam cnt_t TMO_LAST = cnt_t'(TIMEOUT - 1);

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   last_q, last_d;
    cnt_t   cnt_q, cnt_d;
    logic   a_gnt_q, a_gnt_d;
    logic   b_gnt_q, b_gnt_d;
    logic   finish;
    logic   timeout;

    assign timeout = (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    sel_d   = (a_req && b_req) ? ~last_q : b_req;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done || timeout) begin
                    finish  = 1'b1;
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign a_gnt_d = (state_d != ST_IDLE) && !sel_d;
    assign b_gnt_d = (state_d != ST_IDLE) &&  sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            a_gnt_q <= a_gnt_d;
            b_gnt_q <= b_gnt_d;
        end
    end

    // Outputs are held quiet while rst is high, not just after the reset edge.
    assign a_gnt  = a_gnt_q && !rst;
    assign b_gnt  = b_gnt_q && !rst;
    assign a_done = finish && !sel_q && !rst;
    assign b_done = finish &&  sel_q && !rst;
    assign err    = finish && !mem_done && !rst;
    assign mem_en = (state_q == ST_ISSUE) && !rst;
    assign mem_wr = mem_en && (sel_q ? b_wr : a_wr);
    assign rdata  = mem_rdata;

    mux_16w_2_1 u_addr_mux (
        .in0_i (a_addr),
        .in1_i (b_addr),
        .Sel   (sel_q),
        .out_o (mem_addr)
    );

    mux_16w_2_1 u_wdata_mux (
        .in0_i (a_wdata),
        .in1_i (b_wdata),
        .Sel   (sel_q),
        .out_o (mem_wdata)
    );

endmodule
